// File: rtl/ffs_pkg.sv
// rtl/ffs_pkg.sv - shared widths and mode encodings for the FFS encoder/decoder family
package ffs_pkg;

  localparam int LOG2W = 10;
  localparam int W     = 1 << LOG2W;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_MASK   = 1'b1;

  typedef logic [LOG2W-1:0] ffs_idx_t;

endpackage

// File: rtl/ffs_decode_stage.sv
// rtl/ffs_decode_stage.sv - one doubling stage: N-bit partial vector in, 2N-bit vector out
module ffs_decode_stage
  import ffs_pkg::*;
#(
  parameter int N          = 1,
  parameter int IW         = LOG2W,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            in_valid,
  input  logic [N-1:0]    in_vec,
  input  logic            in_mode,
  input  logic [IW-1:0]   in_idx,
  output logic            out_valid,
  output logic [2*N-1:0]  out_vec,
  output logic            out_mode,
  output logic [IW-1:0]   out_idx
);

  logic           valid_q, valid_d;
  logic [2*N-1:0] vec_q, vec_d;
  logic           mode_q, mode_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   fill;

  always_comb begin
    valid_d = valid_q;
    vec_d   = vec_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    fill    = (in_mode == MODE_MASK) ? {N{1'b1}} : {N{1'b0}};
    if (!hold) begin
      valid_d = in_valid;
      mode_d  = in_mode;
      idx_d   = in_idx << 1;
      // Set bit: the partial result lives in the upper half; clear: lower half, upper half filled for masks.
      vec_d   = in_idx[IW-1] ? {in_vec, {N{1'b0}}} : {fill, in_vec};
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    vec_q   <= vec_d;
    mode_q  <= mode_d;
    idx_q   <= idx_d;
    if (reset) begin
      valid_q <= 1'b0;
      if (CLEAR_DATA) vec_q <= '0;
    end
  end

  assign out_valid = valid_q;
  assign out_vec   = vec_q;
  assign out_mode  = mode_q;
  assign out_idx   = idx_q;

endmodule

// File: rtl/ffs_index_decoder.sv
// rtl/ffs_index_decoder.sv - pipelined index to one-hot / thermometer-mask decoder with global stall
module ffs_index_decoder #(
  parameter int LOG2W = ffs_pkg::LOG2W,
  localparam int W    = 1 << LOG2W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG2W-1:0] in_idx,
  input  logic             in_mode,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_vec
);

  logic             stall;
  logic             accept;
  logic             seed;
  logic             mode_eff;
  logic [LOG2W-1:0] idx_rev;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign seed     = ~in_zero;
  assign mode_eff = in_mode & ~in_zero;

  // Each doubling stage decides the finest split first, so the index LSB must be
  // consumed first; reversing once here lets every stage consume its index MSB.
  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < LOG2W; i++) idx_rev[i] = in_idx[LOG2W-1-i];
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    localparam int N = 1 << k;
    logic             valid;
    logic [2*N-1:0]   vec;
    logic             mode;
    logic [LOG2W-1:0] idx;

    if (k == 0) begin : g_head
      ffs_decode_stage #(.N(1), .IW(LOG2W), .CLEAR_DATA(LOG2W == 1)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .hold     (stall),
        .in_valid (accept),
        .in_vec   (seed),
        .in_mode  (mode_eff),
        .in_idx   (idx_rev),
        .out_valid(valid),
        .out_vec  (vec),
        .out_mode (mode),
        .out_idx  (idx)
      );
    end else begin : g_body
      ffs_decode_stage #(.N(N), .IW(LOG2W), .CLEAR_DATA(k == LOG2W - 1)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .hold     (stall),
        .in_valid (g_stage[k-1].valid),
        .in_vec   (g_stage[k-1].vec),
        .in_mode  (g_stage[k-1].mode),
        .in_idx   (g_stage[k-1].idx),
        .out_valid(valid),
        .out_vec  (vec),
        .out_mode (mode),
        .out_idx  (idx)
      );
    end
  end

  assign out_valid = g_stage[LOG2W-1].valid;
  assign out_vec   = g_stage[LOG2W-1].vec;

  logic unused_tail;
  assign unused_tail = ^{g_stage[LOG2W-1].mode, g_stage[LOG2W-1].idx};

endmodule
